grid_renderer: RTL and testbench

//  Reader/display end of the Tetris playfield interface. The game FSM writes the
//  22x10x3-bit color-index grid. This block snapshots that grid once per frame in

---
 rtl/grid_renderer_if.sv | 15 +
 rtl/grid_renderer.sv | 139 +++++++++++++
 tb/tb_grid_renderer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_renderer_if.sv
// rtl/grid_renderer_if.sv - playfield grid in, registered VGA video out.
interface grid_renderer_if;
  logic [21:0][9:0][2:0] grid;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic [9:0]            x;
  logic [9:0]            y;
  logic [11:0]           rgb;
  logic                  frame_start;
  logic                  snap;

  modport master (output grid, input hsync, vsync, de, x, y, rgb, frame_start, snap);
  modport slave  (input grid, output hsync, vsync, de, x, y, rgb, frame_start, snap);
endinterface

// File: rtl/grid_renderer.sv
// rtl/grid_renderer.sv - VGA timing plus per-frame grid snapshot scanned out as 12-bit RGB.
module grid_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_LOG2 = 4,
  parameter int X0        = 240,
  parameter int Y0        = 72,
  parameter int NROWS     = 21,
  parameter int BORDER    = 4
) (
  input logic            clk,
  input logic            rst,
  grid_renderer_if.slave vid
);
  localparam int CELL = 1 << CELL_LOG2;
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BX_BEG = 10'(X0);
  localparam logic [9:0] BX_END = 10'(X0 + 10 * CELL);
  localparam logic [9:0] BY_BEG = 10'(Y0);
  localparam logic [9:0] BY_END = 10'(Y0 + NROWS * CELL);
  localparam logic [9:0] FX_BEG = 10'(X0 - BORDER);
  localparam logic [9:0] FX_END = 10'(X0 + 10 * CELL + BORDER);
  localparam logic [9:0] FY_BEG = 10'(Y0 - BORDER);
  localparam logic [9:0] FY_END = 10'(Y0 + NROWS * CELL + BORDER);

  logic [9:0]            hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [21:0][9:0][2:0] snapshot_q, snapshot_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0]            x_q, x_d, y_q, y_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  frame_start_q, frame_start_d, snap_q, snap_d;

  logic       load, active, in_board, in_frame;
  logic [9:0] hoff, voff;
  logic [3:0] col;
  logic [4:0] row;

  function automatic logic [11:0] pal(input logic [2:0] c);
    case (c)
      3'd1:    pal = 12'h0FF;
      3'd2:    pal = 12'h00F;
      3'd3:    pal = 12'hF80;
      3'd4:    pal = 12'hFF0;
      3'd5:    pal = 12'h0F0;
      3'd6:    pal = 12'h80F;
      3'd7:    pal = 12'hF00;
      default: pal = 12'h000;
    endcase
  endfunction

  always_comb begin
    hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;

    // First blank line: the whole frame has been scanned, so reloading cannot tear.
    load       = (hcnt_q == 10'd0) && (vcnt_q == V_ACT);
    snapshot_d = load ? vid.grid : snapshot_q;

    active   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    in_board = (hcnt_q >= BX_BEG) && (hcnt_q < BX_END) && (vcnt_q >= BY_BEG) && (vcnt_q < BY_END);
    in_frame = (hcnt_q >= FX_BEG) && (hcnt_q < FX_END) && (vcnt_q >= FY_BEG) && (vcnt_q < FY_END);

    hoff = 10'd0;
    voff = 10'd0;
    col  = 4'd0;
    row  = 5'd0;
    rgb_d = 12'h000;
    if (active) begin
      if (in_board) begin
        hoff  = hcnt_q - BX_BEG;
        voff  = vcnt_q - BY_BEG;
        col   = 4'(hoff >> CELL_LOG2);
        row   = 5'(voff >> CELL_LOG2);
        rgb_d = pal(snapshot_q[row][col]);
      end else if (in_frame) begin
        rgb_d = 12'hFFF;
      end
    end

    hsync_d       = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vsync_d       = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    de_d          = active;
    x_d           = hcnt_q;
    y_d           = vcnt_q;
    frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    snap_d        = load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      snapshot_q    <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
      snap_q        <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      snapshot_q    <= snapshot_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      snap_q        <= snap_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.rgb         = rgb_q;
  assign vid.frame_start = frame_start_q;
  assign vid.snap        = snap_q;
endmodule

// File: tb/tb_grid_renderer.sv
// tb/tb_grid_renderer.sv - bench: reduced-geometry instance against a pixel model,
// plus a full 640x480 instance for horizontal timing.
module tb_grid_renderer;
  localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 56, VFP = 2, VS = 2, VBP = 2;
  localparam int CL = 1, X0 = 8, Y0 = 6, NR = 21, BD = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CS = 1 << CL;
  localparam logic [36:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'h000, 1'b0, 1'b0};

  typedef struct {
    string       name;
    int          h;
    int          v;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_renderer_if s_if ();
  grid_renderer_if b_if ();

  grid_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CELL_LOG2(CL), .X0(X0), .Y0(Y0), .NROWS(NR), .BORDER(BD)
  ) u_small (.clk(clk), .rst(rst), .vid(s_if.slave));

  grid_renderer u_full (.clk(clk), .rst(rst), .vid(b_if.slave));

  int errors = 0;
  int checks = 0;
  int t = 0;
  int red_cnt = 0;
  logic [21:0][9:0][2:0] tb_grid;
  int msnap [22][10];
  logic [11:0] cap [VA][HA];
  logic [11:0] pal_m [8] = '{12'h000, 12'h0FF, 12'h00F, 12'hF80, 12'hFF0, 12'h0F0, 12'h80F, 12'hF00};

  bit big_mon = 1'b1;
  int big_t = 0;
  int last_fall = -1;
  int de_start = 0;
  logic prev_hs = 1'b1;
  logic prev_de = 1'b0;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    check(name, 37'(act), 37'(exp));
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v);
    if (h >= HA || v >= VA) return 12'h000;
    if (h >= X0 && h < X0 + 10 * CS && v >= Y0 && v < Y0 + NR * CS)
      return pal_m[msnap[(v - Y0) / CS][(h - X0) / CS]];
    if (h >= X0 - BD && h < X0 + 10 * CS + BD && v >= Y0 - BD && v < Y0 + NR * CS + BD)
      return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic set_cell(input int r, input int c, input logic [2:0] val);
    tb_grid[r][c] = val;
    s_if.grid = tb_grid;
  endtask

  task automatic big_monitor();
    big_t++;
    if (!b_if.hsync && prev_hs) begin
      if (last_fall >= 0) check_int("full_hsync_period", big_t - last_fall, 800);
      last_fall = big_t;
    end
    if (b_if.hsync && !prev_hs && last_fall >= 0) check_int("full_hsync_low", big_t - last_fall, 96);
    if (b_if.de && !prev_de) de_start = big_t;
    if (!b_if.de && prev_de) check_int("full_de_len", big_t - de_start, 640);
    prev_hs = b_if.hsync;
    prev_de = b_if.de;
  endtask

  // One clock: the counter value before the edge is t; outputs after it describe that pixel.
  task automatic step();
    int h, v;
    logic ede;
    logic [36:0] act, exp;
    h = t % HT;
    v = (t / HT) % VT;
    if (h == 0 && v == VA)
      for (int r = 0; r < 22; r++)
        for (int c = 0; c < 10; c++) msnap[r][c] = int'(tb_grid[r][c]);
    @(posedge clk);
    #1;
    t++;
    if (big_mon) big_monitor();
    ede = (h < HA) && (v < VA);
    exp = {!(h >= HA + HFP && h < HA + HFP + HS), !(v >= VA + VFP && v < VA + VFP + VS), ede,
           ede ? 10'(h) : 10'd0, ede ? 10'(v) : 10'd0, model_rgb(h, v),
           (h == 0 && v == 0), (h == 0 && v == VA)};
    act = {s_if.hsync, s_if.vsync, s_if.de, ede ? s_if.x : 10'd0, ede ? s_if.y : 10'd0,
           s_if.rgb, s_if.frame_start, s_if.snap};
    check("pixel", act, exp);
    if (ede) cap[v][h] = s_if.rgb;
    if (s_if.de && s_if.rgb == 12'hF00) red_cnt++;
  endtask

  task automatic run_until(input int h, input int v);
    int n = 0;
    while (!((t % HT) == h && ((t / HT) % VT) == v) && n < 2 * HT * VT) begin
      step();
      n++;
    end
    check_int("run_until_reached", n < 2 * HT * VT, 1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_small"}, {s_if.hsync, s_if.vsync, s_if.de, s_if.x, s_if.y, s_if.rgb,
                             s_if.frame_start, s_if.snap}, RESET_VEC);
    check({name, "_full"}, {b_if.hsync, b_if.vsync, b_if.de, b_if.x, b_if.y, b_if.rgb,
                            b_if.frame_start, b_if.snap}, RESET_VEC);
  endtask

  initial begin
    vec_t t3 [10];
    vec_t t4 [3];
    t3 = '{'{"left_border_outer", 4, 20, 12'hFFF}, '{"left_border_inner", 7, 20, 12'hFFF},
           '{"left_outside", 3, 20, 12'h000},      '{"board_left_edge", 8, 20, 12'h000},
           '{"right_border_outer", 31, 20, 12'hFFF}, '{"right_outside", 32, 20, 12'h000},
           '{"top_border", 15, 2, 12'hFFF},        '{"above_top_border", 15, 1, 12'h000},
           '{"bottom_border", 15, 51, 12'hFFF},    '{"below_bottom_border", 15, 52, 12'h000}};
    t4 = '{'{"floor_is_border", 15, 48, 12'hFFF}, '{"row20_empty", 15, 47, 12'h000},
           '{"below_floor", 15, 52, 12'h000}};

    tb_grid = '0;
    s_if.grid = tb_grid;
    b_if.grid = '0;
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 10; c++) msnap[r][c] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    #2 rst = 1'b0;

    step();
    check_int("frame_start_first_clk", s_if.frame_start, 1);
    step();
    check_int("frame_start_second_clk", s_if.frame_start, 0);

    while (big_t < 2500) step();
    big_mon = 1'b0;

    run_until(0, 0);
    run_until(0, VA);
    foreach (t3[i]) check_int(t3[i].name, cap[t3[i].v][t3[i].h], t3[i].rgb);

    for (int c = 0; c < 10; c++) set_cell(21, c, 3'd7);
    step();
    red_cnt = 0;
    run_until(0, VA);
    foreach (t4[i]) check_int(t4[i].name, cap[t4[i].v][t4[i].h], t4[i].rgb);
    check_int("floor_no_red_pixels", red_cnt, 0);

    step();
    run_until(0, 20);
    set_cell(0, 0, 3'd4);
    run_until(0, VA);
    check_int("no_tear_current_frame", cap[Y0][X0], 12'h000);
    step();
    run_until(0, VA);
    check_int("new_cell_tl", cap[Y0][X0], 12'hFF0);
    check_int("new_cell_tr", cap[Y0][X0 + 1], 12'hFF0);
    check_int("new_cell_bl", cap[Y0 + 1][X0], 12'hFF0);
    check_int("new_cell_br", cap[Y0 + 1][X0 + 1], 12'hFF0);
    check_int("neighbour_cell", cap[Y0][X0 + 2], 12'h000);

    for (int i = 0; i < 3 * HT * VT; i++) begin
      if ($urandom_range(31) == 0)
        set_cell(int'($urandom_range(21)), int'($urandom_range(9)), 3'($urandom_range(7)));
      step();
    end

    run_until(30, 20);
    rst = 1'b1;
    #1;
    check_reset("reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset("reset_held");
    end
    #2 rst = 1'b0;
    t = 0;
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 10; c++) msnap[r][c] = 0;
    step();
    check_int("restart_frame_start", s_if.frame_start, 1);
    step();
    check_int("restart_frame_start_off", s_if.frame_start, 0);
    repeat (4 * HT) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
